// File: rtl/xmodem_loader.sv
// XMODEM-checksum receiver: pops bytes from the UART RX FIFO, packs payload
// little-endian into NB_DATA-bit words, writes them to instruction memory and
// answers each block with ACK/NAK through the UART TX path.
module xmodem_loader #(
  parameter int NB_DATA        = 32,
  parameter int NB_UART_DATA   = 8,
  parameter int NB_ADDR        = 6,
  parameter int BLOCK_SIZE     = 128,
  parameter int NB_TIMEOUT     = 24,
  parameter int TIMEOUT_CYCLES = 10000000
) (
  input  logic                    clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic [NB_UART_DATA-1:0] i_rx_data,
  input  logic                    i_rx_empty,
  output logic                    o_rx_rd,
  output logic                    o_tx_wr,
  output logic [NB_UART_DATA-1:0] o_tx_data,
  output logic                    o_tx_start,
  input  logic                    i_tx_done,
  output logic                    o_mem_we,
  output logic [NB_ADDR-1:0]      o_mem_addr,
  output logic [NB_DATA-1:0]      o_mem_wdata,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error,
  output logic [7:0]              o_blk_count
);
  localparam int BPW    = NB_DATA / 8;
  localparam int WPB    = BLOCK_SIZE / BPW;
  localparam int BSEL_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int WC_W   = $clog2(WPB + 1);
  localparam int BC_W   = $clog2(BLOCK_SIZE + 1);
  localparam logic [7:0] SOH = 8'h01, EOT = 8'h04, CAN = 8'h18;
  localparam logic [7:0] ACK = 8'h06, NAK = 8'h15;

  typedef enum logic [3:0] {
    S_WAIT_HDR, S_BLK, S_BLKN, S_DATA, S_CKSUM,
    S_RESP_WR, S_RESP_START, S_RESP_WAIT, S_DONE, S_ABORT
  } state_t;

  state_t                 state_q, state_d;
  logic                   pop, pop_q, consume, tmo_hit;
  logic                   accept, dup, ovf;
  logic [7:0]             rx_byte, blk_q, blkn_q, exp_q, sum_q, blk_cnt_q;
  logic [7:0]             resp_q, resp_d;
  logic                   eot_q, eot_d;
  logic [BC_W-1:0]        byte_cnt_q;
  logic [BSEL_W-1:0]      bsel_q;
  logic [WC_W-1:0]        word_cnt_q;
  logic [31:0]            blk_base_q, addr_full;
  logic [BPW-1:0][7:0]    word_q, word_nx;
  logic [NB_TIMEOUT-1:0]  tmo_q;
  logic                   busy_q, done_q, err_q, we_q;
  logic [NB_ADDR-1:0]     addr_q;
  logic [NB_DATA-1:0]     wdata_q;

  assign rx_byte = i_rx_data[7:0];

  // Pop gating, timeout detection, checksum verdict and word assembly.
  always_comb begin
    consume   = (state_q inside {S_WAIT_HDR, S_BLK, S_BLKN, S_DATA, S_CKSUM});
    // pop_q blocks the cycle after a pop so the FIFO empty flag can settle
    pop       = consume && i_en && !i_rx_empty && !pop_q && !i_rst;
    tmo_hit   = consume && i_en && !pop && (tmo_q == NB_TIMEOUT'(TIMEOUT_CYCLES - 1));
    accept    = pop && (state_q == S_CKSUM) && (blkn_q == ~blk_q) &&
                (rx_byte == sum_q) && (blk_q == exp_q);
    dup       = pop && (state_q == S_CKSUM) && (blkn_q == ~blk_q) &&
                (rx_byte == sum_q) && (blk_q == exp_q - 8'd1);
    addr_full = blk_base_q + 32'(word_cnt_q);
    ovf       = |addr_full[31:NB_ADDR];
    word_nx   = word_q;
    word_nx[bsel_q] = rx_byte;
  end

  // Next-state: byte-driven protocol walk; a timeout anywhere in the
  // receive path forces a NAK and resynchronises on the next header.
  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    eot_d   = eot_q;
    if (i_en) begin
      case (state_q)
        S_WAIT_HDR: if (pop) begin
          if (rx_byte == SOH)      state_d = S_BLK;
          else if (rx_byte == EOT) begin state_d = S_RESP_WR; resp_d = ACK; eot_d = 1'b1; end
          else if (rx_byte == CAN) state_d = S_ABORT;
        end
        S_BLK:        if (pop) state_d = S_BLKN;
        S_BLKN:       if (pop) state_d = S_DATA;
        S_DATA:       if (pop && byte_cnt_q == BC_W'(BLOCK_SIZE - 1)) state_d = S_CKSUM;
        S_CKSUM: if (pop) begin
          state_d = S_RESP_WR;
          resp_d  = (accept || dup) ? ACK : NAK;
          eot_d   = 1'b0;
        end
        S_RESP_WR:    state_d = S_RESP_START;
        S_RESP_START: state_d = S_RESP_WAIT;
        S_RESP_WAIT:  if (i_tx_done) state_d = eot_q ? S_DONE : S_WAIT_HDR;
        default: ;
      endcase
      if (tmo_hit) begin
        state_d = S_RESP_WR;
        resp_d  = NAK;
        eot_d   = 1'b0;
      end
    end
  end

  // State and response registers.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= S_WAIT_HDR;
      resp_q  <= 8'h00;
      eot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      eot_q   <= eot_d;
    end
  end

  // Datapath: header capture, checksum, word packing, memory writes,
  // block sequencing, timeout counter and sticky status flags.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      pop_q      <= 1'b0;
      tmo_q      <= '0;
      blk_q      <= 8'h00;
      blkn_q     <= 8'h00;
      exp_q      <= 8'd1;
      sum_q      <= 8'h00;
      blk_cnt_q  <= 8'h00;
      byte_cnt_q <= '0;
      bsel_q     <= '0;
      word_cnt_q <= '0;
      blk_base_q <= '0;
      word_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      pop_q <= pop;
      we_q  <= 1'b0;
      if (pop || tmo_hit)      tmo_q <= '0;
      else if (i_en && consume) tmo_q <= tmo_q + NB_TIMEOUT'(1);
      if (pop) begin
        case (state_q)
          S_WAIT_HDR: begin
            if (rx_byte == SOH) begin
              busy_q     <= 1'b1;
              byte_cnt_q <= '0;
              bsel_q     <= '0;
              word_cnt_q <= '0;
              sum_q      <= 8'h00;
            end else if (rx_byte == CAN) begin
              err_q  <= 1'b1;
              busy_q <= 1'b0;
            end
          end
          S_BLK:  blk_q  <= rx_byte;
          S_BLKN: blkn_q <= rx_byte;
          S_DATA: begin
            sum_q      <= sum_q + rx_byte;
            byte_cnt_q <= byte_cnt_q + BC_W'(1);
            word_q     <= word_nx;
            if (bsel_q == BSEL_W'(BPW - 1)) begin
              bsel_q     <= '0;
              word_cnt_q <= word_cnt_q + WC_W'(1);
              // only the expected block may touch memory; duplicates never overwrite
              if (blk_q == exp_q) begin
                if (ovf) err_q <= 1'b1;
                else begin
                  we_q    <= 1'b1;
                  addr_q  <= addr_full[NB_ADDR-1:0];
                  wdata_q <= word_nx;
                end
              end
            end else begin
              bsel_q <= bsel_q + BSEL_W'(1);
            end
          end
          S_CKSUM: if (accept) begin
            exp_q      <= exp_q + 8'd1;
            blk_base_q <= blk_base_q + 32'(WPB);
            blk_cnt_q  <= blk_cnt_q + 8'd1;
          end
          default: ;
        endcase
      end
      if (i_en && state_q == S_RESP_WAIT && i_tx_done && eot_q) begin
        done_q <= 1'b1;
        busy_q <= 1'b0;
      end
    end
  end

  assign o_rx_rd     = pop;
  assign o_tx_wr     = !i_rst && i_en && (state_q == S_RESP_WR);
  assign o_tx_start  = !i_rst && i_en && (state_q == S_RESP_START);
  assign o_tx_data   = NB_UART_DATA'(resp_q);
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_error     = err_q;
  assign o_blk_count = blk_cnt_q;
endmodule

// File: tb/tb_xmodem_loader.sv
// Directed bench for xmodem_loader: RX FIFO model, TX responder and
// memory-write log, with one task per scenario.
module tb_xmodem_loader;
  logic       clk = 1'b0;
  logic       i_rst = 1'b1, i_en = 1'b1, i_tx_done = 1'b0;
  logic       i_rx_empty;
  logic [7:0] i_rx_data;
  logic       o_rx_rd, o_tx_wr, o_tx_start, o_mem_we, o_busy, o_done, o_error;
  logic [7:0] o_tx_data, o_blk_count;
  logic [2:0] o_mem_addr;
  logic [31:0] o_mem_wdata;

  xmodem_loader #(.NB_DATA(32), .NB_UART_DATA(8), .NB_ADDR(3), .BLOCK_SIZE(16),
                  .NB_TIMEOUT(24), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .i_rst(i_rst), .i_en(i_en), .i_rx_data(i_rx_data),
    .i_rx_empty(i_rx_empty), .o_rx_rd(o_rx_rd), .o_tx_wr(o_tx_wr),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_blk_count(o_blk_count));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, last_pop = 0;
  int rx_wp = 0, rx_rp = 0;
  int tx_n = 0, we_n = 0, tx_dly = 0;
  logic [7:0]  rx_buf [0:255];
  logic [7:0]  tx_log [0:63];
  int          tx_cyc [0:63];
  logic [2:0]  we_addr [0:63];
  logic [31:0] we_data [0:63];

  logic [31:0] b1 [0:3] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
  logic [31:0] b2 [0:3] = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};

  assign i_rx_data  = rx_buf[rx_rp[7:0]];
  assign i_rx_empty = (rx_wp == rx_rp);

  // RX FIFO head advances on each pop
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_rx_rd) begin
      rx_rp    <= rx_rp + 1;
      last_pop <= cyc;
    end
  end

  // TX responder (done 3 cycles after start) and output logs
  always @(negedge clk) begin
    i_tx_done = 1'b0;
    if (tx_dly > 0) begin
      tx_dly--;
      if (tx_dly == 0) i_tx_done = 1'b1;
    end
    if (o_tx_start) tx_dly = 3;
    if (o_tx_wr) begin
      tx_log[tx_n % 64] = o_tx_data;
      tx_cyc[tx_n % 64] = cyc;
      tx_n++;
    end
    if (o_mem_we) begin
      we_addr[we_n % 64] = o_mem_addr;
      we_data[we_n % 64] = o_mem_wdata;
      we_n++;
    end
  end

  task automatic push(input logic [7:0] b);
    rx_buf[rx_wp[7:0]] = b;
    rx_wp = rx_wp + 1;
  endtask

  task automatic send_block(input logic [7:0] blk, input logic [7:0] blkn,
                            input logic [7:0] d0, input bit inc, input logic [7:0] cks);
    push(8'h01); push(blk); push(blkn);
    for (int i = 0; i < 16; i++) push(inc ? d0 + 8'(i) : d0);
    push(cks);
  endtask

  task automatic wait_tx(input int n, input string tag);
    int k = 0;
    while (tx_n < n && k < 3000) begin @(negedge clk); k++; end
    total++;
    if (tx_n < n) begin bad++; $display("FAIL %s: tx count %0d want %0d", tag, tx_n, n); end
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst = 1'b1; i_en = 1'b1;
    rx_wp = rx_rp;
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    bit seen = 0;
    do_reset();
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", o_busy); end
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", o_done); end
    total++; if (o_error !== 1'b0) begin bad++; $display("FAIL rst_error: got %b want 0", o_error); end
    total++; if (o_blk_count !== 8'd0) begin bad++; $display("FAIL rst_blkcnt: got %0d want 0", o_blk_count); end
    total++; if ({o_tx_wr, o_tx_start, o_mem_we} !== 3'b000) begin bad++; $display("FAIL rst_strobes: got %b want 000", {o_tx_wr, o_tx_start, o_mem_we}); end
    i_en = 1'b0;
    push(8'h55);
    repeat (6) begin @(negedge clk); if (o_rx_rd) seen = 1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL en_hold_pop: got %b want 0", seen); end
    i_en = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (rx_rp !== rx_wp) begin bad++; $display("FAIL en_resume_pop: left %0d want 0", rx_wp - rx_rp); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL junk_busy: got %b want 0", o_busy); end
  endtask

  task automatic test_single_block();
    int t0, w0;
    do_reset();
    t0 = tx_n; w0 = we_n;
    send_block(8'h01, 8'hFE, 8'h00, 1, 8'h78);
    wait_tx(t0 + 1, "blk1_tx");
    total++; if (tx_log[t0 % 64] !== 8'h06) begin bad++; $display("FAIL blk1_ack: got %h want 06", tx_log[t0 % 64]); end
    total++; if (we_n - w0 !== 4) begin bad++; $display("FAIL blk1_wcnt: got %0d want 4", we_n - w0); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (we_addr[(w0 + i) % 64] !== 3'(i) || we_data[(w0 + i) % 64] !== b1[i]) begin
        bad++; $display("FAIL blk1_mem%0d: got %0d:%h want %0d:%h", i,
                        we_addr[(w0 + i) % 64], we_data[(w0 + i) % 64], i, b1[i]);
      end
    end
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL blk1_busy: got %b want 1", o_busy); end
    push(8'h04);
    wait_tx(t0 + 2, "eot_tx");
    total++; if (tx_log[(t0 + 1) % 64] !== 8'h06) begin bad++; $display("FAIL eot_ack: got %h want 06", tx_log[(t0 + 1) % 64]); end
    total++; if (o_done !== 1'b1) begin bad++; $display("FAIL eot_done: got %b want 1", o_done); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL eot_busy: got %b want 0", o_busy); end
    total++; if (o_blk_count !== 8'd1) begin bad++; $display("FAIL eot_blkcnt: got %0d want 1", o_blk_count); end
  endtask

  task automatic test_bad_cksum();
    int t0, w0;
    do_reset();
    t0 = tx_n; w0 = we_n;
    send_block(8'h01, 8'hFE, 8'h00, 1, 8'h77);
    wait_tx(t0 + 1, "badck_tx");
    total++; if (tx_log[t0 % 64] !== 8'h15) begin bad++; $display("FAIL badck_nak: got %h want 15", tx_log[t0 % 64]); end
    total++; if (o_blk_count !== 8'd0) begin bad++; $display("FAIL badck_blkcnt: got %0d want 0", o_blk_count); end
    send_block(8'h01, 8'hFE, 8'h00, 1, 8'h78);
    wait_tx(t0 + 2, "retx_tx");
    total++; if (tx_log[(t0 + 1) % 64] !== 8'h06) begin bad++; $display("FAIL retx_ack: got %h want 06", tx_log[(t0 + 1) % 64]); end
    total++; if (we_n - w0 !== 8) begin bad++; $display("FAIL retx_wcnt: got %0d want 8", we_n - w0); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (we_addr[(w0 + 4 + i) % 64] !== 3'(i) || we_data[(w0 + 4 + i) % 64] !== b1[i]) begin
        bad++; $display("FAIL retx_mem%0d: got %0d:%h want %0d:%h", i,
                        we_addr[(w0 + 4 + i) % 64], we_data[(w0 + 4 + i) % 64], i, b1[i]);
      end
    end
    total++; if (o_blk_count !== 8'd1) begin bad++; $display("FAIL retx_blkcnt: got %0d want 1", o_blk_count); end
  endtask

  task automatic test_duplicate();
    int t0, w0, w1;
    do_reset();
    t0 = tx_n; w0 = we_n;
    send_block(8'h01, 8'hFE, 8'h00, 1, 8'h78);
    send_block(8'h02, 8'hFD, 8'h10, 1, 8'h78);
    wait_tx(t0 + 2, "dup_pre_tx");
    w1 = we_n;
    send_block(8'h02, 8'hFD, 8'hAA, 0, 8'hA0);
    wait_tx(t0 + 3, "dup_tx");
    total++; if ({tx_log[t0 % 64], tx_log[(t0 + 1) % 64], tx_log[(t0 + 2) % 64]} !== 24'h060606) begin
      bad++; $display("FAIL dup_acks: got %h %h %h want 06 06 06", tx_log[t0 % 64], tx_log[(t0 + 1) % 64], tx_log[(t0 + 2) % 64]);
    end
    total++; if (we_n !== w1) begin bad++; $display("FAIL dup_nowrite: got %0d writes want 0", we_n - w1); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (we_addr[(w0 + 4 + i) % 64] !== 3'(4 + i) || we_data[(w0 + 4 + i) % 64] !== b2[i]) begin
        bad++; $display("FAIL blk2_mem%0d: got %0d:%h want %0d:%h", i,
                        we_addr[(w0 + 4 + i) % 64], we_data[(w0 + 4 + i) % 64], 4 + i, b2[i]);
      end
    end
    total++; if (o_blk_count !== 8'd2) begin bad++; $display("FAIL dup_blkcnt: got %0d want 2", o_blk_count); end
  endtask

  task automatic test_wrong_blk();
    int t0, w0;
    do_reset();
    t0 = tx_n; w0 = we_n;
    send_block(8'h02, 8'hFE, 8'h00, 1, 8'h78);
    wait_tx(t0 + 1, "wrong_tx");
    total++; if (tx_log[t0 % 64] !== 8'h15) begin bad++; $display("FAIL wrong_nak: got %h want 15", tx_log[t0 % 64]); end
    total++; if (we_n !== w0) begin bad++; $display("FAIL wrong_nowrite: got %0d writes want 0", we_n - w0); end
    total++; if (o_blk_count !== 8'd0) begin bad++; $display("FAIL wrong_blkcnt: got %0d want 0", o_blk_count); end
  endtask

  task automatic test_overflow();
    int t0, w0;
    do_reset();
    t0 = tx_n; w0 = we_n;
    send_block(8'h01, 8'hFE, 8'h00, 1, 8'h78);
    send_block(8'h02, 8'hFD, 8'h10, 1, 8'h78);
    wait_tx(t0 + 2, "ovf_pre_tx");
    total++; if (o_error !== 1'b0) begin bad++; $display("FAIL ovf_full_noerr: got %b want 0", o_error); end
    send_block(8'h03, 8'hFC, 8'h20, 1, 8'h78);
    wait_tx(t0 + 3, "ovf_tx");
    total++; if (o_error !== 1'b1) begin bad++; $display("FAIL ovf_error: got %b want 1", o_error); end
    total++; if (tx_log[(t0 + 2) % 64] !== 8'h06) begin bad++; $display("FAIL ovf_ack: got %h want 06", tx_log[(t0 + 2) % 64]); end
    total++; if (we_n - w0 !== 8) begin bad++; $display("FAIL ovf_wcnt: got %0d want 8", we_n - w0); end
    total++; if (o_blk_count !== 8'd3) begin bad++; $display("FAIL ovf_blkcnt: got %0d want 3", o_blk_count); end
  endtask

  task automatic test_cancel();
    int t0;
    do_reset();
    t0 = tx_n;
    push(8'h18);
    repeat (12) @(negedge clk);
    total++; if (o_error !== 1'b1) begin bad++; $display("FAIL can_error: got %b want 1", o_error); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL can_busy: got %b want 0", o_busy); end
    total++; if (tx_n !== t0) begin bad++; $display("FAIL can_notx: got %0d bytes want 0", tx_n - t0); end
  endtask

  task automatic test_timeout();
    int t0, r0, w0, d;
    do_reset();
    r0 = cyc; t0 = tx_n;
    wait_tx(t0 + 2, "tmo_idle_tx");
    d = tx_cyc[t0 % 64] - r0;
    total++; if (d < 998 || d > 1002) begin bad++; $display("FAIL tmo_first: got %0d cycles want 1000", d); end
    total++; if (tx_log[t0 % 64] !== 8'h15 || tx_log[(t0 + 1) % 64] !== 8'h15) begin
      bad++; $display("FAIL tmo_naks: got %h %h want 15 15", tx_log[t0 % 64], tx_log[(t0 + 1) % 64]);
    end
    d = tx_cyc[(t0 + 1) % 64] - tx_cyc[t0 % 64];
    total++; if (d < 1000 || d > 1010) begin bad++; $display("FAIL tmo_period: got %0d cycles want ~1005", d); end
    // stall mid-payload
    do_reset();
    t0 = tx_n; w0 = we_n;
    push(8'h01); push(8'h01); push(8'hFE);
    for (int i = 0; i < 4; i++) push(8'(i));
    wait_tx(t0 + 1, "tmo_stall_tx");
    d = tx_cyc[t0 % 64] - last_pop;
    total++; if (d < 995 || d > 1006) begin bad++; $display("FAIL tmo_stall_time: got %0d cycles want ~1001", d); end
    total++; if (tx_log[t0 % 64] !== 8'h15) begin bad++; $display("FAIL tmo_stall_nak: got %h want 15", tx_log[t0 % 64]); end
    total++; if (we_n - w0 !== 1) begin bad++; $display("FAIL tmo_stall_wcnt: got %0d want 1", we_n - w0); end
    send_block(8'h01, 8'hFE, 8'h00, 1, 8'h78);
    wait_tx(t0 + 2, "tmo_recover_tx");
    total++; if (tx_log[(t0 + 1) % 64] !== 8'h06) begin bad++; $display("FAIL tmo_recover_ack: got %h want 06", tx_log[(t0 + 1) % 64]); end
    total++; if (we_data[(w0 + 4) % 64] !== b1[3]) begin bad++; $display("FAIL tmo_recover_mem: got %h want %h", we_data[(w0 + 4) % 64], b1[3]); end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_bad_cksum();
    test_duplicate();
    test_wrong_blk();
    test_overflow();
    test_cancel();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
